mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- Memory stage of the 5-stage RISC-V core. Sits directly downstream of the EX/MEM pipeline register and consumes its ALU result (address), fnc3, memRead/memWrite, extendSign and store data.
- Runs a req/ack handshake to the data memory and aligns store bytes onto the bus.
- Extracts and extends load data for the MEM/WB register.
- Raises a stall to freeze the upstream pipeline registers while an access is in flight.

Parameters:
- ADDR_W, 32, data-memory address width
- (data width fixed at 32)

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-high reset
- addr_i  in  ADDR_W  effective address (ALU result from EX/MEM)
- st_data_i  in  32  store data (rs2 value)
- fnc3_i  in  3  access size/type (funct3)
- mem_read_i  in  1  load request
- mem_write_i  in  1  store request
- extend_sign_i  in  1  1 = sign-extend loads, 0 = zero-extend
- dmem_req  out  1  bus request
- dmem_we  out  1  1 = write
- dmem_addr  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00})
- dmem_wdata  out  32  lane-replicated store data
- dmem_be  out  4  byte enables
- dmem_ack  in  1  access complete; dmem_rdata valid in the same cycle
- dmem_rdata  in  32  read word
- load_data_o  out  32  aligned, extended load result
- load_valid_o  out  1  one-cycle pulse when load_data_o updates
- stall_o  out  1  freeze EX/MEM and earlier stages
- misalign_o  out  1  misaligned-access pulse (tied 0 unless feature enabled)

Behaviour:
- Reset (async, rst=1):
  - FSM to IDLE.
  - dmem_req, dmem_we, load_valid_o, misalign_o = 0.
  - dmem_addr, dmem_wdata, load_data_o = 0; dmem_be = 0.
  - Asserting reset mid-access drops dmem_req immediately; any later ack is ignored.
- FSM states: IDLE, REQ, DONE.
  - IDLE:
    - If mem_read_i|mem_write_i, stall_o=1 combinationally.
    - Latch address, type, lanes and wdata; next state REQ.
    - Otherwise stall_o=0 and stay in IDLE.
  - REQ:
    - dmem_req=1; stall_o=1.
    - dmem_addr, dmem_we, dmem_wdata and dmem_be are registered and held stable until ack.
    - On dmem_ack: capture and format rdata for loads; next state DONE. Ack may arrive in the first REQ cycle.
    - No ack: stay in REQ indefinitely (no timeout).
  - DONE:
    - dmem_req=0; stall_o=0, so the upstream register advances at this edge.
    - load_valid_o=1 for loads only.
    - Next state IDLE, which evaluates the new instruction.
    - An access is never reissued.
- Latency: minimum 3 cycles per memory instruction (IDLE detect, REQ+ack, DONE). Non-memory instructions add 0 cycles.
- Both mem_read_i and mem_write_i high: treated as a store.
- Size is taken from fnc3_i[1:0]:
  - 00 = byte, 01 = half, 10 = word.
  - 11 is treated as word.
- Stores:
  - Byte: be = 4'b0001<<addr[1:0]; wdata = {4{st_data[7:0]}}.
  - Half: be = addr[1] ? 4'b1100 : 4'b0011; wdata = {2{st_data[15:0]}}.
  - Word: be = 4'b1111; wdata = st_data.
- Loads:
  - dmem_be = 4'b1111.
  - Byte: select rdata byte addr[1:0].
  - Half: select rdata half addr[1].
  - Extend byte/half to 32 bits by sign (extend_sign_i=1) or with zeros.
- load_data_o holds its value until the next load completes; stores do not change it.
- Misalignment without the feature:
  - A half with addr[0]=1 uses addr[1] only.
  - A word ignores addr[1:0].
  - The access is silently forced aligned.

Optional Feature:
- Macro: MISALIGN_TRAP_EN
- Defined:
  - Half with addr[0]=1, or word with addr[1:0]!=0, is detected in IDLE.
  - FSM goes directly to DONE with no bus request.
  - misalign_o=1 for that DONE cycle; load_valid_o=0; load_data_o unchanged.
- Not defined: misalign_o is tied 0 and forced-alignment behaviour applies.

Test Plan:
- LW at addr 0x100, ack 2 cycles after req, rdata 0xDEADBEEF:
  - dmem_addr=0x100, be=1111, stall_o high for 3 cycles.
  - load_data_o=0xDEADBEEF with a single load_valid_o pulse.
- LB at 0x203, sign=1, rdata 0x80112233 -> load_data_o=0xFFFFFF80.
- Same LB with sign=0 -> load_data_o=0x00000080.
- LH at 0x002, sign=0, rdata 0xBEEF1234 -> load_data_o=0x0000BEEF.
- SB at 0x013 with st_data 0x123456A5, ack in first REQ cycle:
  - dmem_we=1, be=1000, wdata=0xA5A5A5A5, dmem_addr=0x010.
  - load_data_o unchanged; total stall 2 cycles.
- Reset asserted while in REQ awaiting ack:
  - dmem_req falls without waiting for a clock edge; FSM in IDLE.
  - Late ack produces no load_valid_o.
- LW at 0x102:
  - Without macro: dmem_addr=0x100, normal load.
  - With MISALIGN_TRAP_EN: no dmem_req, misalign_o pulse, load_data_o unchanged.

Source files
------------

// File: rtl/mem_access_stage.sv
// Memory-access stage of the 5-stage RISC-V core.
// Drives a req/ack handshake to data memory. Stores are lane-aligned onto the bus.
// Load data is extracted from the returned word and sign- or zero-extended.
// stall_o holds the upstream pipeline registers while an access is in flight.
// Optional build macro MISALIGN_TRAP_EN: a misaligned half or word access skips the bus
// and pulses misalign_o. Without the macro, misaligned accesses are silently forced aligned.
module mem_access_stage #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       st_data_i,
  input  logic [2:0]        fnc3_i,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic              extend_sign_i,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  output logic [3:0]        dmem_be,
  input  logic              dmem_ack,
  input  logic [31:0]       dmem_rdata,
  output logic [31:0]       load_data_o,
  output logic              load_valid_o,
  output logic              stall_o,
  output logic              misalign_o
);

  typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

  localparam logic [1:0] SzByte = 2'b00;
  localparam logic [1:0] SzHalf = 2'b01;

  state_e            state_q;
  logic              dmem_req_q;
  logic              dmem_we_q;
  logic [ADDR_W-1:0] dmem_addr_q;
  logic [31:0]       dmem_wdata_q;
  logic [3:0]        dmem_be_q;
  logic [31:0]       load_data_q;
  logic              load_valid_q;
  logic [1:0]        size_q;
  logic [1:0]        off_q;
  logic              sign_q;

  logic              mem_op;
  logic              is_store;
  logic [1:0]        size_in;
  logic [3:0]        be_d;
  logic [31:0]       wdata_d;
  logic [31:0]       load_fmt_d;
  logic              misaligned;

  // funct3[2] only duplicates extend_sign_i (LBU/LHU) and is not needed here
  logic              unused_fnc3;
  assign unused_fnc3 = fnc3_i[2];

  assign mem_op   = mem_read_i | mem_write_i;
  // Read and write together behave as a store
  assign is_store = mem_write_i;
  // Size 11 falls into the word path below
  assign size_in  = fnc3_i[1:0];

  // Byte enables and lane-replicated write data for the incoming instruction
  always_comb begin
    be_d    = 4'b1111;
    wdata_d = st_data_i;
    if (is_store) begin
      unique case (size_in)
        SzByte: begin
          be_d    = 4'b0001 << addr_i[1:0];
          wdata_d = {4{st_data_i[7:0]}};
        end
        SzHalf: begin
          be_d    = addr_i[1] ? 4'b1100 : 4'b0011;
          wdata_d = {2{st_data_i[15:0]}};
        end
        default: begin
          be_d    = 4'b1111;
          wdata_d = st_data_i;
        end
      endcase
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic misalign_q;

  // Half needs addr[0]=0; word (incl. size 11) needs addr[1:0]=0
  always_comb begin
    misaligned = 1'b0;
    unique case (size_in)
      SzByte:  misaligned = 1'b0;
      SzHalf:  misaligned = addr_i[0];
      default: misaligned = |addr_i[1:0];
    endcase
  end

  assign misalign_o = misalign_q;
`else
  assign misaligned = 1'b0;
  assign misalign_o = 1'b0;
`endif

  // Extract the addressed byte/half from the returned word and extend it
  always_comb begin
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    rd_byte    = dmem_rdata[8*off_q +: 8];
    rd_half    = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    load_fmt_d = dmem_rdata;
    unique case (size_q)
      SzByte:  load_fmt_d = {{24{sign_q & rd_byte[7]}}, rd_byte};
      SzHalf:  load_fmt_d = {{16{sign_q & rd_half[15]}}, rd_half};
      default: load_fmt_d = dmem_rdata;
    endcase
  end

  // Access FSM with registered bus and result outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      dmem_be_q    <= 4'b0000;
      load_data_q  <= '0;
      load_valid_q <= 1'b0;
      size_q       <= 2'b00;
      off_q        <= 2'b00;
      sign_q       <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      misalign_q   <= 1'b0;
`endif
    end else begin
      load_valid_q <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      misalign_q   <= 1'b0;
`endif
      unique case (state_q)
        StIdle: begin
          if (mem_op) begin
            size_q <= size_in;
            off_q  <= addr_i[1:0];
            sign_q <= extend_sign_i;
            if (misaligned) begin
              // Trap: no bus activity, result register untouched
`ifdef MISALIGN_TRAP_EN
              misalign_q <= 1'b1;
`endif
              state_q <= StDone;
            end else begin
              dmem_req_q   <= 1'b1;
              dmem_we_q    <= is_store;
              dmem_addr_q  <= {addr_i[ADDR_W-1:2], 2'b00};
              dmem_wdata_q <= wdata_d;
              dmem_be_q    <= be_d;
              state_q      <= StReq;
            end
          end
        end
        StReq: begin
          if (dmem_ack) begin
            dmem_req_q <= 1'b0;
            if (!dmem_we_q) begin
              load_data_q  <= load_fmt_d;
              load_valid_q <= 1'b1;
            end
            state_q <= StDone;
          end
        end
        StDone: begin
          // Upstream advances on this edge; IDLE then sees the next instruction
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Freeze upstream from detection until the ack edge
  assign stall_o = ((state_q == StIdle) && mem_op) || (state_q == StReq);

  assign dmem_req     = dmem_req_q;
  assign dmem_we      = dmem_we_q;
  assign dmem_addr    = dmem_addr_q;
  assign dmem_wdata   = dmem_wdata_q;
  assign dmem_be      = dmem_be_q;
  assign load_data_o  = load_data_q;
  assign load_valid_o = load_valid_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage.
module tb_mem_access_stage;

  logic        clk;
  logic        rst;
  logic [31:0] addr_i;
  logic [31:0] st_data_i;
  logic [2:0]  fnc3_i;
  logic        mem_read_i;
  logic        mem_write_i;
  logic        extend_sign_i;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic [31:0] load_data_o;
  logic        load_valid_o;
  logic        stall_o;
  logic        misalign_o;

  int n_checks = 0;
  int n_errors = 0;

  // Observations from the last run_op
  int          r_stall;
  int          r_lv;
  int          r_mis;
  int          r_req;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic [31:0] r_ldata;
  logic        r_done;
  logic [31:0] exp_ld;

  mem_access_stage #(.ADDR_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .addr_i        (addr_i),
    .st_data_i     (st_data_i),
    .fnc3_i        (fnc3_i),
    .mem_read_i    (mem_read_i),
    .mem_write_i   (mem_write_i),
    .extend_sign_i (extend_sign_i),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_wdata    (dmem_wdata),
    .dmem_be       (dmem_be),
    .dmem_ack      (dmem_ack),
    .dmem_rdata    (dmem_rdata),
    .load_data_o   (load_data_o),
    .load_valid_o  (load_valid_o),
    .stall_o       (stall_o),
    .misalign_o    (misalign_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one memory instruction at a negedge and hold it until the DONE cycle.
  // ack_dly = number of REQ cycles without ack before ack is returned.
  task automatic run_op(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [2:0] f3, input logic sx,
                        input int ack_dly, input logic [31:0] rdata);
    int req_cnt;
    int guard;
    mem_read_i    = rd;
    mem_write_i   = wr;
    addr_i        = addr;
    st_data_i     = data;
    fnc3_i        = f3;
    extend_sign_i = sx;
    r_stall = 0; r_lv = 0; r_mis = 0; r_req = 0; r_done = 1'b0;
    r_we = 1'bx; r_addr = 'x; r_wdata = 'x; r_be = 'x;
    req_cnt = 0;
    guard   = 0;
    #1;
    if (stall_o) r_stall++;
    while (!r_done && guard < 50) begin
      @(negedge clk);
      guard++;
      dmem_ack = 1'b0;
      if (load_valid_o) r_lv++;
      if (misalign_o) r_mis++;
      if (!stall_o) begin
        r_done  = 1'b1;
        r_ldata = load_data_o;
        if (dmem_req) r_req++;
      end else begin
        r_stall++;
        if (dmem_req) begin
          if (req_cnt == 0) begin
            r_req   = 1;
            r_we    = dmem_we;
            r_addr  = dmem_addr;
            r_wdata = dmem_wdata;
            r_be    = dmem_be;
          end
          if (req_cnt == ack_dly) begin
            dmem_ack   = 1'b1;
            dmem_rdata = rdata;
          end
          req_cnt++;
        end
      end
    end
    check_eq("op_completes", {31'd0, r_done}, 32'd1);
    mem_read_i  = 1'b0;
    mem_write_i = 1'b0;
    @(negedge clk);
    if (load_valid_o) r_lv++;
    if (misalign_o) r_mis++;
  endtask

  initial begin
    rst = 1'b1;
    addr_i = '0; st_data_i = '0; fnc3_i = '0;
    mem_read_i = 1'b0; mem_write_i = 1'b0; extend_sign_i = 1'b0;
    dmem_ack = 1'b0; dmem_rdata = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_req", {31'd0, dmem_req}, 32'd0);
    check_eq("rst_we", {31'd0, dmem_we}, 32'd0);
    check_eq("rst_addr", dmem_addr, 32'd0);
    check_eq("rst_wdata", dmem_wdata, 32'd0);
    check_eq("rst_be", {28'd0, dmem_be}, 32'd0);
    check_eq("rst_ldata", load_data_o, 32'd0);
    check_eq("rst_lv", {31'd0, load_valid_o}, 32'd0);
    check_eq("rst_mis", {31'd0, misalign_o}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("idle_stall", {31'd0, stall_o}, 32'd0);

    // LW 0x100, ack in second REQ cycle
    run_op(1'b1, 1'b0, 32'h100, 32'h0, 3'b010, 1'b1, 1, 32'hDEADBEEF);
    check_eq("lw_addr", r_addr, 32'h100);
    check_eq("lw_be", {28'd0, r_be}, 32'hF);
    check_eq("lw_we", {31'd0, r_we}, 32'd0);
    check_eq("lw_stall", r_stall, 3);
    check_eq("lw_lv", r_lv, 1);
    check_eq("lw_data", r_ldata, 32'hDEADBEEF);

    run_op(1'b1, 1'b0, 32'h203, 32'h0, 3'b000, 1'b1, 0, 32'h80112233);
    check_eq("lb_s_data", r_ldata, 32'hFFFFFF80);
    check_eq("lb_s_addr", r_addr, 32'h200);
    check_eq("lb_s_stall", r_stall, 2);

    run_op(1'b1, 1'b0, 32'h203, 32'h0, 3'b100, 1'b0, 0, 32'h80112233);
    check_eq("lb_u_data", r_ldata, 32'h00000080);

    run_op(1'b1, 1'b0, 32'h002, 32'h0, 3'b101, 1'b0, 2, 32'hBEEF1234);
    check_eq("lh_u_data", r_ldata, 32'h0000BEEF);
    check_eq("lh_u_stall", r_stall, 4);
    exp_ld = 32'h0000BEEF;

    // SB 0x013, ack in first REQ cycle
    run_op(1'b0, 1'b1, 32'h013, 32'h123456A5, 3'b000, 1'b0, 0, 32'h0);
    check_eq("sb_we", {31'd0, r_we}, 32'd1);
    check_eq("sb_be", {28'd0, r_be}, 32'h8);
    check_eq("sb_wdata", r_wdata, 32'hA5A5A5A5);
    check_eq("sb_addr", r_addr, 32'h010);
    check_eq("sb_ldata", r_ldata, exp_ld);
    check_eq("sb_stall", r_stall, 2);
    check_eq("sb_lv", r_lv, 0);

    run_op(1'b0, 1'b1, 32'h006, 32'h0000CAFE, 3'b001, 1'b0, 0, 32'h0);
    check_eq("sh_be", {28'd0, r_be}, 32'hC);
    check_eq("sh_wdata", r_wdata, 32'hCAFECAFE);

    run_op(1'b0, 1'b1, 32'h008, 32'h01234567, 3'b010, 1'b0, 1, 32'h0);
    check_eq("sw_be", {28'd0, r_be}, 32'hF);
    check_eq("sw_wdata", r_wdata, 32'h01234567);

    run_op(1'b1, 1'b0, 32'h000, 32'h0, 3'b001, 1'b1, 0, 32'h12348001);
    check_eq("lh_s_data", r_ldata, 32'hFFFF8001);
    exp_ld = 32'hFFFF8001;

    // Read and write together act as a store
    run_op(1'b1, 1'b1, 32'h020, 32'h11223344, 3'b010, 1'b0, 0, 32'h99999999);
    check_eq("rw_we", {31'd0, r_we}, 32'd1);
    check_eq("rw_ldata", r_ldata, exp_ld);
    check_eq("rw_lv", r_lv, 0);

    // Size 11 behaves as word
    run_op(1'b0, 1'b1, 32'h024, 32'hA1B2C3D4, 3'b011, 1'b0, 0, 32'h0);
    check_eq("s11_be", {28'd0, r_be}, 32'hF);
    check_eq("s11_wdata", r_wdata, 32'hA1B2C3D4);

    // Misaligned LW and LH
    run_op(1'b1, 1'b0, 32'h102, 32'h0, 3'b010, 1'b0, 0, 32'h55667788);
`ifdef MISALIGN_TRAP_EN
    check_eq("lw_mis_req", r_req, 0);
    check_eq("lw_mis_pulse", r_mis, 1);
    check_eq("lw_mis_lv", r_lv, 0);
    check_eq("lw_mis_ldata", r_ldata, exp_ld);
`else
    check_eq("lw_mis_addr", r_addr, 32'h100);
    check_eq("lw_mis_ldata", r_ldata, 32'h55667788);
    check_eq("lw_mis_pulse", r_mis, 0);
    exp_ld = 32'h55667788;
`endif
    run_op(1'b1, 1'b0, 32'h003, 32'h0, 3'b101, 1'b0, 0, 32'hAABBCCDD);
`ifdef MISALIGN_TRAP_EN
    check_eq("lh_mis_req", r_req, 0);
    check_eq("lh_mis_pulse", r_mis, 1);
    check_eq("lh_mis_ldata", r_ldata, exp_ld);
`else
    check_eq("lh_mis_ldata", r_ldata, 32'h0000AABB);
    check_eq("lh_mis_pulse", r_mis, 0);
`endif

    // Reset while waiting for ack
    mem_read_i = 1'b1; addr_i = 32'h300; fnc3_i = 3'b010; extend_sign_i = 1'b0;
    @(negedge clk);
    check_eq("rq_req_up", {31'd0, dmem_req}, 32'd1);
    #2;
    rst = 1'b1;
    mem_read_i = 1'b0;
    #1;
    check_eq("rq_req_drop", {31'd0, dmem_req}, 32'd0);
    check_eq("rq_stall", {31'd0, stall_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    dmem_ack = 1'b1; dmem_rdata = 32'h77777777;
    r_lv = 0;
    repeat (3) begin
      @(negedge clk);
      if (load_valid_o) r_lv++;
    end
    dmem_ack = 1'b0;
    check_eq("late_ack_lv", r_lv, 0);
    check_eq("late_ack_req", {31'd0, dmem_req}, 32'd0);
    check_eq("late_ack_ldata", load_data_o, 32'd0);

    // Recovery after reset
    run_op(1'b1, 1'b0, 32'h001, 32'h0, 3'b100, 1'b0, 0, 32'h0000FF00);
    check_eq("post_rst_data", r_ldata, 32'h000000FF);
    check_eq("post_rst_lv", r_lv, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
